// File: rtl/regfile_arbiter_if.sv
// Requester-side bus for regfile_arbiter: two independent request/ack ports (A and B)
// carrying address, write data and registered read-data return.
interface regfile_arbiter_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rvalid
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_rvalid
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin front end for an external 16x8 register file, with a
// 16-cycle bulk-initialise sequence that writes (init_val + index) to every register.
module regfile_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  regfile_arbiter_if.slave bus,
  input  logic       init_start,
  input  logic [7:0] init_val,
  output logic       init_busy,
  output logic       init_done,
  output logic       rf_en,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata
);
  localparam int unsigned AW       = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned IDX_LAST = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] ival_q, ival_d;
  logic          last_b_q, last_b_d;   // 1: B was granted most recently
  logic          done_q, done_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          a_ack_c, b_ack_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ival_q     <= '0;
      last_b_q   <= 1'b1;
      done_q     <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ival_q     <= ival_d;
      last_b_q   <= last_b_d;
      done_q     <= done_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Next-state, arbitration and register-file drive
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ival_d     = ival_q;
    last_b_d   = last_b_q;
    done_d     = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_ack_c    = 1'b0;
    b_ack_c    = 1'b0;
    rf_en      = 1'b0;
    rf_addr    = '0;
    rf_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_INIT;
          idx_d   = '0;
          ival_d  = init_val;
        end else if (bus.a_req && (!bus.b_req || last_b_q)) begin
          a_ack_c = 1'b1;
        end else if (bus.b_req) begin
          b_ack_c = 1'b1;
        end
      end
      ST_INIT: begin
        rf_en    = 1'b1;
        rf_addr  = idx_q;
        rf_wdata = DW'(ival_q + DW'(idx_q));
        idx_d    = AW'(idx_q + AW'(1));
        if (idx_q == AW'(IDX_LAST)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (a_ack_c) begin
      last_b_d = 1'b0;
      rf_en    = bus.a_we;
      rf_addr  = bus.a_addr;
      rf_wdata = bus.a_wdata;
      if (!bus.a_we) begin
        a_rdata_d  = rf_rdata;
        a_rvalid_d = 1'b1;
      end
    end

    if (b_ack_c) begin
      last_b_d = 1'b1;
      rf_en    = bus.b_we;
      rf_addr  = bus.b_addr;
      rf_wdata = bus.b_wdata;
      if (!bus.b_we) begin
        b_rdata_d  = rf_rdata;
        b_rvalid_d = 1'b1;
      end
    end
  end

  assign bus.a_ack    = a_ack_c;
  assign bus.b_ack    = b_ack_c;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign init_busy    = (state_q == ST_INIT);
  assign init_done    = done_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x8 register file attached.
module tb_regfile_arbiter;
  logic       clk;
  logic       rst_n;
  logic       init_start;
  logic [7:0] init_val;
  logic       init_busy;
  logic       init_done;
  logic       rf_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .init_start (init_start),
    .init_val   (init_val),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .rf_en      (rf_en),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .rf_rdata   (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: no reset, combinational read
  always @(posedge clk) if (rf_en) mem[rf_addr] <= rf_wdata;
  assign rf_rdata = mem[rf_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; init_start = 1'b0; init_val = 8'h00;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 4'h0; bus.a_wdata = 8'h00;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 4'h0; bus.b_wdata = 8'h00;
    mem[1] = 8'h11; mem[2] = 8'h22;

    // Reset state
    #12;
    chk("rst_a_rdata", 32'(bus.a_rdata), 32'h00);
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'h0);
    chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'h0);
    chk("rst_init_busy", 32'(init_busy), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_rf_en", 32'(rf_en), 32'h0);
    rst_n = 1'b1;
    tick();

    // Both requesters hold reads: A, B, A, B
    bus.a_req = 1'b1; bus.a_addr = 4'h1;
    bus.b_req = 1'b1; bus.b_addr = 4'h2;
    #1;
    chk("rr0_a_ack", 32'(bus.a_ack), 32'h1);
    chk("rr0_b_ack", 32'(bus.b_ack), 32'h0);
    chk("rr0_rf_addr", 32'(rf_addr), 32'h1);
    tick();
    chk("rr1_a_ack", 32'(bus.a_ack), 32'h0);
    chk("rr1_b_ack", 32'(bus.b_ack), 32'h1);
    chk("rr1_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    chk("rr1_a_rdata", 32'(bus.a_rdata), 32'h11);
    tick();
    chk("rr2_a_ack", 32'(bus.a_ack), 32'h1);
    chk("rr2_b_ack", 32'(bus.b_ack), 32'h0);
    chk("rr2_b_rvalid", 32'(bus.b_rvalid), 32'h1);
    chk("rr2_b_rdata", 32'(bus.b_rdata), 32'h22);
    tick();
    chk("rr3_a_ack", 32'(bus.a_ack), 32'h0);
    chk("rr3_b_ack", 32'(bus.b_ack), 32'h1);
    tick();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    #1;
    chk("idle_rf_en", 32'(rf_en), 32'h0);
    chk("idle_rf_addr", 32'(rf_addr), 32'h0);
    chk("idle_rf_wdata", 32'(rf_wdata), 32'h00);

    // A writes 0x5A to reg 3, then reads it back
    tick();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'h3; bus.a_wdata = 8'h5A;
    #1;
    chk("wr_a_ack", 32'(bus.a_ack), 32'h1);
    chk("wr_rf_en", 32'(rf_en), 32'h1);
    chk("wr_rf_addr", 32'(rf_addr), 32'h3);
    chk("wr_rf_wdata", 32'(rf_wdata), 32'h5A);
    tick();
    chk("wr_no_rvalid", 32'(bus.a_rvalid), 32'h0);
    bus.a_we = 1'b0;
    #1;
    chk("rd_a_ack", 32'(bus.a_ack), 32'h1);
    chk("rd_rf_en", 32'(rf_en), 32'h0);
    tick();
    bus.a_req = 1'b0;
    chk("rd_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    chk("rd_a_rdata", 32'(bus.a_rdata), 32'h5A);
    tick();
    chk("rd_rvalid_pulse", 32'(bus.a_rvalid), 32'h0);
    chk("rd_rdata_hold", 32'(bus.a_rdata), 32'h5A);

    // Bulk init 0xF8 with a B read of reg 9 held across it
    init_start = 1'b1; init_val = 8'hF8;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'h9;
    #1;
    chk("is_b_ack", 32'(bus.b_ack), 32'h0);
    chk("is_rf_en", 32'(rf_en), 32'h0);
    tick();
    init_start = 1'b0; init_val = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin init_start = 1'b1; init_val = 8'h33; end
      if (i == 6) begin init_start = 1'b0; init_val = 8'h00; end
      #1;
      chk($sformatf("init%0d_busy", i), 32'(init_busy), 32'h1);
      chk($sformatf("init%0d_b_ack", i), 32'(bus.b_ack), 32'h0);
      chk($sformatf("init%0d_rf_addr", i), 32'(rf_addr), 32'(i));
      chk($sformatf("init%0d_rf_wdata", i), 32'(rf_wdata), 32'((8'hF8 + i) & 8'hFF));
      tick();
    end
    #1;
    chk("id_busy", 32'(init_busy), 32'h0);
    chk("id_done", 32'(init_done), 32'h1);
    chk("id_b_ack", 32'(bus.b_ack), 32'h1);
    chk("id_rf_addr", 32'(rf_addr), 32'h9);
    chk("mem0", 32'(mem[0]), 32'hF8);
    chk("mem7", 32'(mem[7]), 32'hFF);
    chk("mem8", 32'(mem[8]), 32'h00);
    chk("mem15", 32'(mem[15]), 32'h07);
    tick();
    bus.b_req = 1'b0;
    chk("id_done_pulse", 32'(init_done), 32'h0);
    chk("id_b_rvalid", 32'(bus.b_rvalid), 32'h1);
    chk("id_b_rdata", 32'(bus.b_rdata), 32'h01);

    // Reset at init index 7 with init_val 0x10
    tick();
    init_start = 1'b1; init_val = 8'h10;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("ab_rf_addr", 32'(rf_addr), 32'h7);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", 32'(init_busy), 32'h0);
    chk("ab_rf_en", 32'(rf_en), 32'h0);
    chk("ab_b_rdata", 32'(bus.b_rdata), 32'h00);
    tick();
    chk("ab_done", 32'(init_done), 32'h0);
    chk("ab_mem0", 32'(mem[0]), 32'h10);
    chk("ab_mem6", 32'(mem[6]), 32'h16);
    chk("ab_mem7", 32'(mem[7]), 32'hFF);
    rst_n = 1'b1;
    tick();
    chk("ab_done_after", 32'(init_done), 32'h0);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'h0;
    #1;
    chk("ab_a_ack", 32'(bus.a_ack), 32'h1);
    tick();
    bus.a_req = 1'b0;
    chk("ab_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    chk("ab_a_rdata", 32'(bus.a_rdata), 32'h10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have no parameters; the register file is fixed at 16 x 8 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a_req / b_req  input  1  requester A / B access request, held until acked.
REQ-006 a_we / b_we  input  1  1 = write access, 0 = read access.
REQ-007 a_addr / b_addr  input  4  register index.
REQ-008 a_wdata / b_wdata  input  8  write data.
REQ-009 a_ack / b_ack  output  1  combinational; access performed at the end of this cycle.
REQ-010 a_rdata / b_rdata  output  8  registered read data.
REQ-011 a_rvalid / b_rvalid  output  1  one-cycle pulse; xx_rdata is valid.
REQ-012 init_start  input  1  pulse; bulk-initialise all 16 registers.
REQ-013 init_val  input  8  base value for bulk init.
REQ-014 init_busy  output  1  high while the init sequence runs.
REQ-015 init_done  output  1  one-cycle pulse after the last init write.
REQ-016 rf_en  output  1  register-file write enable.
REQ-017 rf_addr  output  4  register-file address.
REQ-018 rf_wdata  output  8  register-file write data.
REQ-019 rf_rdata  input  8  register-file combinational read data.

Function
REQ-020 The FSM SHALL have two states: IDLE and INIT.
REQ-021 In IDLE with exactly one request active, that requester SHALL be acked the same cycle.
REQ-022 In IDLE with both requests active, the block SHALL ack the requester not granted most recently; after reset, A wins the first tie.
REQ-023 The last-grant pointer SHALL update only on an ack.
REQ-024 At most one ack SHALL be high per cycle.
REQ-025 The selected requester SHALL drive rf_addr; rf_wdata SHALL be its wdata, and rf_en = ack & we.
REQ-026 When no ack is given, rf_en SHALL be 0, rf_addr 0 and rf_wdata 0.
REQ-027 On an acked read, rf_rdata SHALL be captured into xx_rdata at that edge, and xx_rvalid SHALL pulse the following cycle (read latency 1).
REQ-028 xx_rdata SHALL hold its value until the next read for that requester.
REQ-029 An acked write SHALL NOT generate rvalid.
REQ-030 init_start in IDLE SHALL move the FSM to INIT with index counter 0; init has priority over simultaneous requests, which receive no ack that cycle.
REQ-031 In INIT, the block SHALL write (init_val + index) mod 256 to register index on each cycle for index 0..15 (16 cycles).
REQ-032 init_val SHALL be sampled once, on entry to INIT.
REQ-033 In INIT, no ack SHALL be issued, init_busy SHALL be 1, and init_start SHALL be ignored.
REQ-034 After the index-15 write, the FSM SHALL return to IDLE, and init_done SHALL pulse in the first IDLE cycle; requests may be acked in that same cycle.
REQ-035 A request held across INIT SHALL be serviced after INIT, under normal arbitration.

Reset
REQ-036 On rst_n low, the block SHALL force asynchronously: state IDLE, index 0, last-grant = B, xx_rdata 0x00, xx_rvalid 0, init_busy 0, init_done 0.
REQ-037 Reset mid-INIT SHALL abort the sequence with no init_done; already-written register-file contents are not restored (the register file has no reset).
REQ-038 After reset release, the first edge SHALL behave as IDLE.

Verification
REQ-039 A writes 0x5A to reg 3, then reads reg 3 -> a_ack each cycle, rf_en=1 only on the write, a_rvalid one cycle after the read ack with a_rdata=0x5A.
REQ-040 a_req and b_req held continuously as reads -> acks alternate A,B,A,B starting with A after reset; never both high.
REQ-041 init_start with init_val=0xF8 -> init_busy for 16 cycles, registers 0..15 = 0xF8..0xFF,0x00..0x07 (wrap), init_done pulses once, then read reg 9 returns 0x01.
REQ-042 init_start coincident with b_req; b_req held -> no b_ack during INIT; b_ack in the init_done cycle.
REQ-043 rst_n asserted at init index 7 -> outputs at reset values immediately, no init_done; registers 0..6 keep new values; a subsequent A read of reg 0 is acked normally.
